// File: rtl/exec_sequencer_if.sv
// Handshake/status bundle between the phase sequencer and the datapath.
// The datapath side drives go, decode flags and mem_ack.
interface exec_sequencer_if #(
  parameter int CW = 16
);
  logic          go;
  logic          dec_rf_write;
  logic          dec_mem_read;
  logic          dec_mem_write;
  logic          dec_halt;
  logic          mem_ack;
  logic          ir_load;
  logic          pc_en;
  logic          carry_en;
  logic          rf_we;
  logic          mem_req;
  logic          mem_we;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] cycle_ct;
  logic [CW-1:0] instr_ct;

  modport master (
    output go, dec_rf_write, dec_mem_read,
    output dec_mem_write, dec_halt, mem_ack,
    input  ir_load, pc_en, carry_en, rf_we,
    input  mem_req, mem_we, busy, done, err,
    input  cycle_ct, instr_ct
  );

  modport slave (
    input  go, dec_rf_write, dec_mem_read,
    input  dec_mem_write, dec_halt, mem_ack,
    output ir_load, pc_en, carry_en, rf_we,
    output mem_req, mem_we, busy, done, err,
    output cycle_ct, instr_ct
  );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/exec/mem/writeback phase sequencer
// with variable-latency data-memory handshake and timeout.
module exec_sequencer #(
  parameter int CW          = 16,
  parameter int MEM_TIMEOUT = 8
) (
  input logic               clk,
  input logic               reset_n,
  exec_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_DONE,
    S_ERR
  } state_e;

  localparam int WW = 16;
  localparam logic [WW-1:0] WLAST =
    (MEM_TIMEOUT == 0) ? '0 : WW'(MEM_TIMEOUT - 1);
  localparam logic [CW-1:0] CMAX = '1;

  state_e        state_q, state_d;
  logic [WW-1:0] wait_q, wait_d;
  logic [CW-1:0] cycle_q, cycle_d;
  logic [CW-1:0] instr_q, instr_d;

  logic ir_load_c, pc_en_c, carry_en_c, rf_we_c;
  logic mem_req_c, mem_we_c, busy_c, done_c, err_c;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_q  <= '0;
      cycle_q <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      cycle_q <= cycle_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    cycle_d    = cycle_q;
    instr_d    = instr_q;
    ir_load_c  = 1'b0;
    pc_en_c    = 1'b0;
    carry_en_c = 1'b0;
    rf_we_c    = 1'b0;
    mem_req_c  = 1'b0;
    mem_we_c   = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    err_c      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.go) begin
          state_d = S_FETCH;
          cycle_d = '0;
          instr_d = '0;
        end
      end
      S_FETCH: begin
        ir_load_c = 1'b1;
        busy_c    = 1'b1;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        busy_c  = 1'b1;
        state_d = bus.dec_halt ? S_DONE : S_EXEC;
      end
      S_EXEC: begin
        carry_en_c = 1'b1;
        busy_c     = 1'b1;
        state_d    = (bus.dec_mem_read | bus.dec_mem_write)
                   ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req_c = 1'b1;
        mem_we_c  = bus.dec_mem_write;
        busy_c    = 1'b1;
        if (bus.mem_ack) begin
          state_d = S_WB;
          wait_d  = '0;
        end else if (MEM_TIMEOUT != 0 && wait_q == WLAST) begin
          state_d = S_ERR;
          wait_d  = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_WB: begin
        pc_en_c = 1'b1;
        rf_we_c = bus.dec_rf_write & ~bus.dec_mem_write;
        busy_c  = 1'b1;
        state_d = S_FETCH;
        if (instr_q != CMAX) instr_d = instr_q + 1'b1;
      end
      S_DONE: begin
        done_c = 1'b1;
        if (bus.go) begin
          state_d = S_FETCH;
          cycle_d = '0;
          instr_d = '0;
        end
      end
      S_ERR: begin
        err_c = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // restart clears only happen in non-busy states, so no overlap
    if (busy_c && cycle_q != CMAX) cycle_d = cycle_q + 1'b1;
  end

  assign bus.ir_load  = ir_load_c;
  assign bus.pc_en    = pc_en_c;
  assign bus.carry_en = carry_en_c;
  assign bus.rf_we    = rf_we_c;
  assign bus.mem_req  = mem_req_c;
  assign bus.mem_we   = mem_we_c;
  assign bus.busy     = busy_c;
  assign bus.done     = done_c;
  assign bus.err      = err_c;
  assign bus.cycle_ct = cycle_q;
  assign bus.instr_ct = instr_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Directed bench for exec_sequencer; CW=4 build so the
// counter saturation is reachable in a short run.
module tb_exec_sequencer;

  localparam int CW = 4;

  localparam logic [8:0] IDL = 9'h000;
  localparam logic [8:0] FE  = 9'h104;
  localparam logic [8:0] DE  = 9'h004;
  localparam logic [8:0] EX  = 9'h044;
  localparam logic [8:0] LDM = 9'h014;
  localparam logic [8:0] STM = 9'h01C;
  localparam logic [8:0] WBR = 9'h0A4;
  localparam logic [8:0] WBS = 9'h084;
  localparam logic [8:0] DN  = 9'h002;
  localparam logic [8:0] ER  = 9'h001;

  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_bad = 0;
  int   nreq;

  exec_sequencer_if #(.CW(CW)) bus ();

  exec_sequencer #(
    .CW          (CW),
    .MEM_TIMEOUT (8)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  logic [8:0] ov;
  assign ov = {bus.ir_load, bus.pc_en, bus.carry_en,
               bus.rf_we, bus.mem_req, bus.mem_we,
               bus.busy, bus.done, bus.err};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic dec(input logic rf, input logic rd,
                     input logic wr, input logic h);
    bus.dec_rf_write  = rf;
    bus.dec_mem_read  = rd;
    bus.dec_mem_write = wr;
    bus.dec_halt      = h;
  endtask

  task automatic cnt(input string tag,
                     input int cyc, input int ins);
    chk({tag, "_cyc"}, 32'(bus.cycle_ct), cyc);
    chk({tag, "_ins"}, 32'(bus.instr_ct), ins);
  endtask

  initial begin
    reset_n     = 1'b0;
    bus.go      = 1'b0;
    bus.mem_ack = 1'b0;
    dec(0, 0, 0, 0);
    tick();
    tick();
    chk("rst_out", 32'(ov), 32'(IDL));
    cnt("rst", 0, 0);
    reset_n = 1'b1;
    tick();
    chk("idle", 32'(ov), 32'(IDL));

    // three ALU ops; stray go and mem_ack are ignored
    dec(1, 0, 0, 0);
    bus.mem_ack = 1'b1;
    bus.go      = 1'b1;
    tick();
    bus.go = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("alu%0d_if", i), 32'(ov), 32'(FE));
      tick();
      bus.go = 1'b1;
      chk($sformatf("alu%0d_de", i), 32'(ov), 32'(DE));
      tick();
      bus.go = 1'b0;
      chk($sformatf("alu%0d_ex", i), 32'(ov), 32'(EX));
      tick();
      chk($sformatf("alu%0d_wb", i), 32'(ov), 32'(WBR));
      tick();
    end
    dec(1, 0, 0, 1);
    chk("halt_if", 32'(ov), 32'(FE));
    tick();
    chk("halt_de", 32'(ov), 32'(DE));
    tick();
    chk("halt_done", 32'(ov), 32'(DN));
    cnt("halt", 14, 3);
    bus.mem_ack = 1'b0;

    // go from DONE restarts with cleared counters
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    chk("restart_if", 32'(ov), 32'(FE));
    cnt("restart", 0, 0);

    // load, ack on third MEM cycle
    dec(1, 1, 0, 0);
    tick();
    tick();
    tick();
    for (int k = 1; k <= 3; k++) begin
      if (k == 3) bus.mem_ack = 1'b1;
      chk($sformatf("ld_mem%0d", k), 32'(ov), 32'(LDM));
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("ld_wb", 32'(ov), 32'(WBR));
    tick();
    chk("ld_next", 32'(ov), 32'(FE));
    cnt("ld", 7, 1);

    // read+write together is a store; ack on first MEM cycle
    dec(1, 1, 1, 0);
    tick();
    tick();
    tick();
    bus.mem_ack = 1'b1;
    chk("st_mem", 32'(ov), 32'(STM));
    tick();
    bus.mem_ack = 1'b0;
    chk("st_wb", 32'(ov), 32'(WBS));
    tick();
    chk("st_next", 32'(ov), 32'(FE));
    cnt("st", 12, 2);

    // ack on the last allowed MEM cycle; cycle_ct saturates
    dec(1, 1, 0, 0);
    tick();
    tick();
    tick();
    nreq = 0;
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) bus.mem_ack = 1'b1;
      if (ov == LDM) nreq++;
      tick();
    end
    bus.mem_ack = 1'b0;
    chk("ack8_req", nreq, 8);
    chk("ack8_wb", 32'(ov), 32'(WBR));
    tick();
    chk("ack8_next", 32'(ov), 32'(FE));
    cnt("sat", 15, 3);

    // halt wins over memory flags; counters hold in DONE
    dec(0, 1, 1, 1);
    tick();
    chk("hm_de", 32'(ov), 32'(DE));
    tick();
    chk("hm_done", 32'(ov), 32'(DN));
    tick();
    chk("hm_hold", 32'(ov), 32'(DN));
    cnt("hm", 15, 3);

    // load with no ack times out after 8 MEM cycles
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    cnt("to_start", 0, 0);
    dec(1, 1, 0, 0);
    tick();
    tick();
    tick();
    nreq = 0;
    for (int k = 0; k < 20 && bus.busy; k++) begin
      if (bus.mem_req) nreq++;
      tick();
    end
    chk("to_req", nreq, 8);
    chk("to_err", 32'(ov), 32'(ER));
    cnt("to", 11, 0);
    bus.go = 1'b1;
    tick();
    tick();
    bus.go = 1'b0;
    chk("to_go", 32'(ov), 32'(ER));
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("to_rst", 32'(ov), 32'(IDL));

    // reset while in MEM aborts the access
    bus.go = 1'b1;
    tick();
    bus.go = 1'b0;
    tick();
    tick();
    tick();
    chk("mr_mem", 32'(ov), 32'(LDM));
    reset_n = 1'b0;
    tick();
    chk("mr_rst", 32'(ov), 32'(IDL));
    cnt("mr", 0, 0);
    reset_n = 1'b1;
    tick();
    chk("mr_idle", 32'(ov), 32'(IDL));

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_bad);
    $finish;
  end

endmodule
